// File: rtl/alu_operand_seq.sv
// Operand sequencer for a combinational ALU: collects A (with op/carry) and B beats,
// holds them for EXEC_CYCLES settle cycles, captures the result and holds it until consumed.
`timescale 1ns/1ps
module alu_operand_seq #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [1:0] op_in,
    input  logic       cin_in,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       S1,
    output logic       S0,
    output logic       Cin,
    input  logic [7:0] G,
    input  logic       Overflow,
    input  logic [7:0] Du,
    output logic [7:0] R,
    output logic       R_ovf,
    output logic [7:0] R_du,
    output logic       Err,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {IDLE, GET_B, EXEC, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic [1:0] op_q, op_d;
    logic       cin_q, cin_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] r_q, r_d, r_du_q, r_du_d, op_count_q, op_count_d;
    logic       r_ovf_q, r_ovf_d, err_q, err_d, res_valid_q, res_valid_d;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cin_d       = cin_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        r_ovf_d     = r_ovf_q;
        r_du_d      = r_du_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        op_count_d  = op_count_q;
        din_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    a_d     = din;
                    op_d    = op_in;
                    cin_d   = cin_in;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    b_d     = din;
                    cnt_d   = 4'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    // Divide by zero overrides whatever the ALU returns.
                    if (op_q == 2'b11 && b_q == 8'h00) begin
                        r_d     = 8'hFF;
                        r_du_d  = a_q;
                        r_ovf_d = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        r_d     = G;
                        r_du_d  = Du;
                        r_ovf_d = Overflow;
                        err_d   = 1'b0;
                    end
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            op_q        <= 2'b00;
            cin_q       <= 1'b0;
            cnt_q       <= 4'd0;
            r_q         <= 8'h00;
            r_ovf_q     <= 1'b0;
            r_du_q      <= 8'h00;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            op_count_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cin_q       <= cin_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            r_ovf_q     <= r_ovf_d;
            r_du_q      <= r_du_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign S1        = op_q[1];
    assign S0        = op_q[0];
    assign Cin       = cin_q;
    assign R         = r_q;
    assign R_ovf     = r_ovf_q;
    assign R_du      = r_du_q;
    assign Err       = err_q;
    assign res_valid = res_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: doc/alu_operand_seq.md
ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, which is the number of settle cycles the ALU inputs are held before capture (legal 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port din, input, 8 bits: operand data beat.
REQ-005 SHALL have port din_valid, input, 1 bit: din (and op_in/cin_in on the A beat) valid.
REQ-006 SHALL have port din_ready, output, 1 bit: block accepts a beat this cycle.
REQ-007 SHALL have port op_in, input, 2 bits: operation select, sampled with operand A; 00 add, 01 sub, 10 mul, 11 div.
REQ-008 SHALL have port cin_in, input, 1 bit: carry/borrow-in, sampled with operand A.
REQ-009 SHALL have ports A and B, outputs, 8 bits each, plus S1, S0 and Cin, outputs, 1 bit each: registered operands and controls driven to the ALU.
REQ-010 SHALL have ports G (8 bits), Overflow (1 bit) and Du (8 bits), inputs: combinational result, overflow and remainder returned from the ALU.
REQ-011 SHALL have ports R (8 bits), R_ovf (1 bit), R_du (8 bits) and Err (1 bit), outputs: captured result, overflow, remainder and divide-by-zero flag.
REQ-012 SHALL have port res_valid, output, 1 bit: R/R_ovf/R_du/Err valid.
REQ-013 SHALL have port res_ready, input, 1 bit: downstream consumes the result.
REQ-014 SHALL have port op_count, output, 8 bits: count of consumed results.

Function
REQ-015 SHALL implement FSM states IDLE, GET_B, EXEC, DONE.
REQ-016 SHALL drive din_ready=1 in IDLE and GET_B only, and 0 in EXEC and DONE.
REQ-017 In IDLE, a handshake (din_valid&din_ready) SHALL latch A<=din, {S1,S0}<=op_in, Cin<=cin_in, and move to GET_B.
REQ-018 In GET_B, a handshake SHALL latch B<=din, clear the settle counter, and move to EXEC.
REQ-019 Beats offered while din_ready=0 SHALL be ignored, with no state or register change.
REQ-020 A, B, S1, S0 and Cin SHALL remain stable from their latch until the next accepted A beat.
REQ-021 In EXEC, the 4-bit settle counter SHALL increment each cycle; on the cycle where counter==EXEC_CYCLES-1, the block SHALL capture R<=G, R_ovf<=Overflow, R_du<=Du, Err<=0, set res_valid, and move to DONE.
REQ-022 Latency SHALL be fixed: res_valid rises exactly EXEC_CYCLES clock edges after the edge that accepted B.
REQ-023 Divide by zero: if {S1,S0}==11 and B==0 at capture, the block SHALL capture R<=8'hFF, R_du<=A, R_ovf<=0, Err<=1, ignoring G/Overflow/Du.
REQ-024 In DONE, res_valid and R/R_ovf/R_du/Err SHALL be held while res_ready=0.
REQ-025 In DONE with res_ready=1, the block SHALL, on that edge, clear res_valid, increment op_count (mod 256, FF wraps to 00), and go to IDLE; R/R_ovf/R_du/Err keep their values.
REQ-026 res_ready SHALL be ignored outside DONE.
REQ-027 No new operation SHALL begin in the cycle the result is consumed; the A beat is accepted earliest on the cycle after.

Reset
REQ-028 While rst=1 at a clock edge, the FSM SHALL enter IDLE and A, B, S1, S0, Cin, R, R_ovf, R_du, Err, res_valid, op_count and the settle counter SHALL all be 0.
REQ-029 Reset SHALL override any handshake in the same cycle, including in any state mid-operation, and the partial operation SHALL be discarded.
REQ-030 din_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-031 Add, EXEC_CYCLES=1: A=0x0F with op 00 and cin 1, then B=0x01 -> R=0x11, R_ovf=0, Err=0, res_valid high 1 edge after the B accept.
REQ-032 Add overflow, EXEC_CYCLES=3: A=0xFF with op 00 and cin 0, then B=0x01 -> R=0x00, R_ovf=1, res_valid high exactly 3 edges after the B accept.
REQ-033 Divide: A=23 with op 11, then B=5 -> R=4, R_du=3, Err=0; divide by zero: A=9 with op 11, then B=0 -> R=0xFF, R_du=0x09, Err=1.
REQ-034 Backpressure: hold res_ready=0 for 5 cycles in DONE while pulsing din_valid with din=0xAA -> R and res_valid stay stable, din_ready=0, A/B unchanged; raise res_ready -> op_count +1 and IDLE on the next cycle.
REQ-035 Wrap: preset op_count to 0xFF by running 255 operations, then complete one more -> op_count=0x00.
REQ-036 Reset mid-EXEC: assert rst for 1 cycle -> next cycle IDLE, din_ready=1, res_valid=0, and all outputs listed in REQ-028 equal 0.
